// File: rtl/chrono_core.sv
// Counting core of the start/stop chronometer: BCD mm:ss.cc live count,
// registered display digits with a LIVE/HOLD lap view, and a rollover pulse.
module chrono_core #(
  parameter int unsigned MIN_LIMIT = 60
) (
  input  logic       clk_ms,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       lr_pulse,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] cs_t,
  output logic [3:0] cs_u,
  output logic       hold,
  output logic       wrap
);

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } bcd_time_t;

  typedef enum logic {LIVE = 1'b0, HOLD = 1'b1} disp_state_e;

  localparam int unsigned MIN_MAX   = MIN_LIMIT - 1;
  localparam logic [3:0]  MIN_MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0]  MIN_MAX_U = 4'(MIN_MAX % 10);

  bcd_time_t   live_q, live_d;
  bcd_time_t   disp_q, disp_d;
  disp_state_e state_q, state_d;
  logic        wrap_q, wrap_d;

  logic inc, c_cs_t, c_sec_u, c_sec_t, c_min, min_at_max;

  // Ripple-style carry enables: each stage advances when all lower digits roll.
  assign inc        = run && tick;
  assign c_cs_t     = inc && (live_q.cs_u == 4'd9);
  assign c_sec_u    = c_cs_t && (live_q.cs_t == 4'd9);
  assign c_sec_t    = c_sec_u && (live_q.sec_u == 4'd9);
  assign c_min      = c_sec_t && (live_q.sec_t == 4'd5);
  assign min_at_max = (live_q.min_t == MIN_MAX_T) && (live_q.min_u == MIN_MAX_U);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    live_d  = live_q;
    disp_d  = disp_q;
    state_d = state_q;
    wrap_d  = 1'b0;

    if (inc)     live_d.cs_u  = c_cs_t  ? 4'd0 : live_q.cs_u  + 4'd1;
    if (c_cs_t)  live_d.cs_t  = c_sec_u ? 4'd0 : live_q.cs_t  + 4'd1;
    if (c_sec_u) live_d.sec_u = c_sec_t ? 4'd0 : live_q.sec_u + 4'd1;
    if (c_sec_t) live_d.sec_t = c_min   ? 4'd0 : live_q.sec_t + 4'd1;
    if (c_min) begin
      if (min_at_max) begin
        live_d.min_t = 4'd0;
        live_d.min_u = 4'd0;
        wrap_d       = 1'b1;
      end else if (live_q.min_u == 4'd9) begin
        live_d.min_u = 4'd0;
        live_d.min_t = live_q.min_t + 4'd1;
      end else begin
        live_d.min_u = live_q.min_u + 4'd1;
      end
    end

    unique case (state_q)
      LIVE: begin
        // Display tracks the pre-increment count; a lap press just stops tracking.
        disp_d = live_q;
        if (lr_pulse) begin
          if (run) state_d = HOLD;
          else     live_d  = '0;
        end
      end
      HOLD: begin
        if (lr_pulse) state_d = LIVE;
      end
      default: state_d = LIVE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      live_q  <= '0;
      disp_q  <= '0;
      state_q <= LIVE;
      wrap_q  <= 1'b0;
    end else begin
      live_q  <= live_d;
      disp_q  <= disp_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign min_t = disp_q.min_t;
  assign min_u = disp_q.min_u;
  assign sec_t = disp_q.sec_t;
  assign sec_u = disp_q.sec_u;
  assign cs_t  = disp_q.cs_t;
  assign cs_u  = disp_q.cs_u;
  assign hold  = (state_q == HOLD);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_chrono_core.sv
// Directed bench for chrono_core: a default-limit instance for counting, lap and
// clear behaviour, plus a MIN_LIMIT=1 instance whose rollover fits a short run.
module tb_chrono_core;

  logic clk_ms = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic run = 1'b0;
  logic lr_pulse = 1'b0;

  logic [3:0] a_min_t, a_min_u, a_sec_t, a_sec_u, a_cs_t, a_cs_u;
  logic [3:0] b_min_t, b_min_u, b_sec_t, b_sec_u, b_cs_t, b_cs_u;
  logic       a_hold, a_wrap, b_hold, b_wrap;
  logic [23:0] disp_a, disp_b;

  int compared = 0;
  int mismatched = 0;
  int wrap_cnt_a = 0;
  int wrap_cnt_b = 0;
  int bad_digit_cnt = 0;

  chrono_core #(.MIN_LIMIT(60)) dut_a (
    .clk_ms(clk_ms), .rst(rst), .tick(tick), .run(run), .lr_pulse(lr_pulse),
    .min_t(a_min_t), .min_u(a_min_u), .sec_t(a_sec_t), .sec_u(a_sec_u),
    .cs_t(a_cs_t), .cs_u(a_cs_u), .hold(a_hold), .wrap(a_wrap)
  );

  chrono_core #(.MIN_LIMIT(1)) dut_b (
    .clk_ms(clk_ms), .rst(rst), .tick(tick), .run(run), .lr_pulse(lr_pulse),
    .min_t(b_min_t), .min_u(b_min_u), .sec_t(b_sec_t), .sec_u(b_sec_u),
    .cs_t(b_cs_t), .cs_u(b_cs_u), .hold(b_hold), .wrap(b_wrap)
  );

  assign disp_a = {a_min_t, a_min_u, a_sec_t, a_sec_u, a_cs_t, a_cs_u};
  assign disp_b = {b_min_t, b_min_u, b_sec_t, b_sec_u, b_cs_t, b_cs_u};

  always #5 clk_ms = ~clk_ms;

  // Running tallies of rollover pulses and out-of-range digits, sampled mid-cycle.
  always @(negedge clk_ms) begin
    if (a_wrap === 1'b1) wrap_cnt_a++;
    if (b_wrap === 1'b1) wrap_cnt_b++;
    if (a_cs_u > 4'd9 || a_cs_t > 4'd9 || a_sec_u > 4'd9 || a_sec_t > 4'd5 ||
        a_min_u > 4'd9 || a_min_t > 4'd5)
      bad_digit_cnt++;
    if (b_cs_u > 4'd9 || b_cs_t > 4'd9 || b_sec_u > 4'd9 || b_sec_t > 4'd5 ||
        b_min_u != 4'd0 || b_min_t != 4'd0)
      bad_digit_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic r, input logic l);
    tick = t;
    run = r;
    lr_pulse = l;
    @(posedge clk_ms);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_disp", disp_a, 24'h000000);
    check("reset_hold", {23'd0, a_hold}, 24'd0);
    check("reset_wrap", {23'd0, a_wrap}, 24'd0);

    // Basic count: display shows 00:01.50 one cycle after the last tick.
    ticks(150);
    check("basic_lag", disp_a, 24'h000149);
    cyc(1'b0, 1'b1, 1'b0);
    check("basic_disp", disp_a, 24'h000150);
    check("basic_hold", {23'd0, a_hold}, 24'd0);

    // Lap freeze and release.
    do_reset();
    ticks(1234);
    cyc(1'b0, 1'b1, 1'b1);
    check("lap_hold", {23'd0, a_hold}, 24'd1);
    check("lap_snap", disp_a, 24'h001234);
    ticks(500);
    check("lap_frozen", disp_a, 24'h001234);
    cyc(1'b0, 1'b1, 1'b1);
    check("lap_release", {23'd0, a_hold}, 24'd0);
    cyc(1'b0, 1'b1, 1'b0);
    check("lap_live", disp_a, 24'h001734);

    // Lap press coinciding with a tick: snapshot is pre-increment.
    do_reset();
    ticks(10);
    cyc(1'b1, 1'b1, 1'b1);
    check("lap_tick_snap", disp_a, 24'h000010);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("lap_tick_live", disp_a, 24'h000011);

    // Stop and clear.
    do_reset();
    ticks(300);
    repeat (50) cyc(1'b1, 1'b0, 1'b0);
    check("stop_ignore", disp_a, 24'h000300);
    cyc(1'b0, 1'b0, 1'b1);
    check("clear_edge", disp_a, 24'h000300);
    cyc(1'b0, 1'b0, 1'b0);
    check("clear_disp", disp_a, 24'h000000);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("clear_again", disp_a, 24'h000000);
    check("clear_hold", {23'd0, a_hold}, 24'd0);

    // Stop inside HOLD: first press only releases, second clears.
    do_reset();
    ticks(200);
    cyc(1'b0, 1'b1, 1'b1);
    check("hstop_snap", disp_a, 24'h000200);
    cyc(1'b0, 1'b0, 1'b0);
    check("hstop_runchg", {23'd0, a_hold}, 24'd1);
    cyc(1'b0, 1'b0, 1'b1);
    check("hstop_release", {23'd0, a_hold}, 24'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("hstop_live", disp_a, 24'h000200);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("hstop_clear", disp_a, 24'h000000);

    // Carry chain on A and rollover on B (max 00:59.99).
    do_reset();
    ticks(5999);
    cyc(1'b0, 1'b1, 1'b0);
    check("carry_pre_a", disp_a, 24'h005999);
    check("max_b", disp_b, 24'h005999);
    cyc(1'b1, 1'b1, 1'b0);
    check("wrap_b_high", {23'd0, b_wrap}, 24'd1);
    check("wrap_a_low", {23'd0, a_wrap}, 24'd0);
    cyc(1'b0, 1'b1, 1'b0);
    check("wrap_b_pulse", {23'd0, b_wrap}, 24'd0);
    check("wrap_b_disp", disp_b, 24'h000000);
    check("carry_a_disp", disp_a, 24'h010000);

    // Reset in HOLD with tick and lap press asserted: reset wins.
    cyc(1'b0, 1'b1, 1'b1);
    check("prerst_hold", {23'd0, a_hold}, 24'd1);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("rst_disp", disp_a, 24'h000000);
    check("rst_hold", {23'd0, a_hold}, 24'd0);
    check("rst_wrap", {23'd0, a_wrap}, 24'd0);
    cyc(1'b0, 1'b1, 1'b1);
    check("rst_fsm_live", {23'd0, a_hold}, 24'd1);
    check("rst_cleared", disp_a, 24'h000000);
    cyc(1'b0, 1'b0, 1'b0);

    check("wrap_cnt_a", 24'(wrap_cnt_a), 24'd0);
    check("wrap_cnt_b", 24'(wrap_cnt_b), 24'd1);
    check("digit_range", 24'(bad_digit_cnt), 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
